dec_iter: RTL and testbench

DEC_ITER -- requirements
Module: dec_iter

---
 rtl/dec_iter.sv | 106 ++++++++++
 tb/tb_dec_iter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_iter.sv
// Iterative decrementer: subtracts STEP from a start value n times, one iteration
// per clock, then holds the result until the consumer takes it.
module dec_iter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int STEP  = 1,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [CNT_W-1:0] n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             borrow,
    output logic             zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH:0]   diff;

    // The extra top bit of the difference is the underflow flag of one iteration.
    assign diff = {1'b0, acc_q} - {1'b0, STEP_V};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        if (flush) begin
            state_d  = IDLE;
            acc_d    = '0;
            cnt_d    = '0;
            borrow_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_d    = a;
                        cnt_d    = n;
                        borrow_d = 1'b0;
                        state_d  = (n == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (!diff[WIDTH]) begin
                        acc_d = diff[WIDTH-1:0];
                    end else begin
                        borrow_d = 1'b1;
                        acc_d    = SAT ? '0 : diff[WIDTH-1:0];
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign c         = acc_q;
    assign borrow    = borrow_q;
    assign zero      = out_valid && (acc_q == '0);

endmodule

// File: tb/tb_dec_iter.sv
// Scoreboard bench for dec_iter: four parameter variants share one stimulus stream;
// expected results come from a closed-form arithmetic model of the decrement rules.
module tb_dec_iter;

    localparam int NUM = 4;
    localparam int STEPS [NUM] = '{1, 1, 3, 0};
    localparam bit SATS  [NUM] = '{1'b0, 1'b1, 1'b0, 1'b0};

    typedef struct {
        logic [7:0] c;
        logic       borrow;
        int         rise;
    } exp_t;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       flush    = 1'b0;
    logic       inValid  = 1'b0;
    logic       outReady = 1'b0;
    logic [7:0] aBus     = '0;
    logic [3:0] nBus     = '0;

    logic       inReadyOut [NUM];
    logic       validOut   [NUM];
    logic       borrowOut  [NUM];
    logic       zeroOut    [NUM];
    logic       busyOut    [NUM];
    logic [7:0] cOut       [NUM];

    exp_t expQ [NUM][$];
    int   checks     = 0;
    int   errors     = 0;
    int   cycleCount = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    for (genvar g = 0; g < NUM; g++) begin : gDut
        dec_iter #(
            .WIDTH(8),
            .CNT_W(4),
            .STEP (STEPS[g]),
            .SAT  (SATS[g])
        ) u (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .in_valid (inValid),
            .in_ready (inReadyOut[g]),
            .a        (aBus),
            .n        (nBus),
            .out_valid(validOut[g]),
            .out_ready(outReady),
            .c        (cOut[g]),
            .borrow   (borrowOut[g]),
            .zero     (zeroOut[g]),
            .busy     (busyOut[g])
        );
    end

    // Net effect of n subtractions: the total taken is n*step; any shortfall means
    // some iteration underflowed, and the result either wraps or clamps at zero.
    function automatic exp_t model(input int aVal, input int nVal, input int step,
                                   input bit sat, input int rise);
        exp_t r;
        int   remaining;
        remaining = aVal - nVal * step;
        r.borrow  = (remaining < 0);
        if (remaining < 0 && sat) r.c = 8'd0;
        else                      r.c = 8'(remaining);
        r.rise = rise;
        return r;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one time unit after a rising edge; holds the operand until it is taken.
    task automatic applyStimulus(input logic [7:0] aIn, input logic [3:0] nIn,
                                 input bit randomReady);
        int waited = 0;
        bit done   = 1'b0;
        inValid = 1'b1;
        aBus    = aIn;
        nBus    = nIn;
        while (!done) begin
            if (randomReady) outReady = 1'($urandom_range(0, 1));
            if (inReadyOut[0] && !flush) begin
                for (int i = 0; i < NUM; i++)
                    expQ[i].push_back(model(int'(aIn), int'(nIn), STEPS[i], SATS[i],
                                            cycleCount + 1 + int'(nIn)));
                done = 1'b1;
            end else if (waited >= 300) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout: got no in_ready, expected acceptance");
                done = 1'b1;
            end
            waited++;
            tick();
        end
        inValid = 1'b0;
    endtask

    task automatic drainAll(input bit randomReady);
        int waited = 0;
        while ((expQ[0].size() != 0 || busyOut[0]) && waited < 400) begin
            outReady = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            waited++;
        end
        if (expQ[0].size() != 0 || busyOut[0]) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", expQ[0].size());
        end
    endtask

    task automatic checkCleared(input string tag);
        for (int i = 0; i < NUM; i++) begin
            checkOutput($sformatf("u%0d.%s_c", i, tag), int'(cOut[i]), 0);
            checkOutput($sformatf("u%0d.%s_borrow", i, tag), int'(borrowOut[i]), 0);
            checkOutput($sformatf("u%0d.%s_zero", i, tag), int'(zeroOut[i]), 0);
            checkOutput($sformatf("u%0d.%s_valid", i, tag), int'(validOut[i]), 0);
            checkOutput($sformatf("u%0d.%s_busy", i, tag), int'(busyOut[i]), 0);
            checkOutput($sformatf("u%0d.%s_in_ready", i, tag), int'(inReadyOut[i]), 1);
        end
    endtask

    logic       prevValid [NUM];
    logic       prevHs    [NUM];
    logic [7:0] lastC     [NUM];
    logic       lastB     [NUM];
    int         riseAt    [NUM];

    // Monitor: pops the scoreboard on every result handshake, and checks that a held
    // result stays put and that a consumed result leaves c/borrow behind.
    always @(negedge clk) begin
        for (int i = 0; i < NUM; i++) begin
            if (!rst_n) begin
                prevValid[i] = 1'b0;
                prevHs[i]    = 1'b0;
            end else begin
                if (prevHs[i]) begin
                    checkOutput($sformatf("u%0d.hold_c", i), int'(cOut[i]), int'(lastC[i]));
                    checkOutput($sformatf("u%0d.hold_borrow", i), int'(borrowOut[i]), int'(lastB[i]));
                    checkOutput($sformatf("u%0d.valid_drop", i), int'(validOut[i]), 0);
                    checkOutput($sformatf("u%0d.zero_drop", i), int'(zeroOut[i]), 0);
                end
                if (validOut[i]) begin
                    if (!prevValid[i]) begin
                        riseAt[i] = cycleCount;
                    end else begin
                        checkOutput($sformatf("u%0d.stable_c", i), int'(cOut[i]), int'(lastC[i]));
                        checkOutput($sformatf("u%0d.stable_borrow", i), int'(borrowOut[i]), int'(lastB[i]));
                    end
                    checkOutput($sformatf("u%0d.in_ready_done", i), int'(inReadyOut[i]), 0);
                    if (outReady) begin
                        if (expQ[i].size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL u%0d.unexpected_result: got c=%0d, expected none",
                                     i, cOut[i]);
                        end else begin
                            exp_t e;
                            e = expQ[i].pop_front();
                            checkOutput($sformatf("u%0d.c", i), int'(cOut[i]), int'(e.c));
                            checkOutput($sformatf("u%0d.borrow", i), int'(borrowOut[i]), int'(e.borrow));
                            checkOutput($sformatf("u%0d.zero", i), int'(zeroOut[i]), int'(e.c == 8'd0));
                            checkOutput($sformatf("u%0d.latency", i), riseAt[i], e.rise);
                        end
                    end
                    lastC[i] = cOut[i];
                    lastB[i] = borrowOut[i];
                end
                prevHs[i]    = validOut[i] && outReady;
                prevValid[i] = validOut[i];
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t m;
        int   w;

        tick();
        tick();
        checkCleared("reset");
        rst_n = 1'b1;
        outReady = 1'b1;

        applyStimulus(8'd10, 4'd3, 1'b0);
        drainAll(1'b0);
        applyStimulus(8'd1, 4'd3, 1'b0);
        drainAll(1'b0);
        applyStimulus(8'h5A, 4'd0, 1'b0);
        drainAll(1'b0);
        applyStimulus(8'd4, 4'd2, 1'b0);
        drainAll(1'b0);
        applyStimulus(8'd0, 4'd15, 1'b0);
        drainAll(1'b0);

        // Back-pressure: result held while a competing operand waits.
        outReady = 1'b0;
        applyStimulus(8'd10, 4'd2, 1'b0);
        w = 0;
        while (!validOut[0] && w < 20) begin
            tick();
            w++;
        end
        checkOutput("stall_valid_seen", int'(validOut[0]), 1);
        m = model(10, 2, STEPS[0], SATS[0], 0);
        inValid = 1'b1;
        aBus    = 8'd99;
        nBus    = 4'd1;
        for (int k = 0; k < 5; k++) begin
            checkOutput("stall_c", int'(cOut[0]), int'(m.c));
            checkOutput("stall_in_ready", int'(inReadyOut[0]), 0);
            tick();
        end
        outReady = 1'b1;
        tick();
        checkOutput("ready_after_hs", int'(inReadyOut[0]), 1);
        applyStimulus(8'd99, 4'd1, 1'b0);
        drainAll(1'b0);

        // Flush on the second RUN edge abandons the operation.
        applyStimulus(8'd20, 4'd5, 1'b0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkCleared("flush");
        for (int i = 0; i < NUM; i++) expQ[i].delete();
        repeat (8) tick();

        flush   = 1'b1;
        inValid = 1'b1;
        aBus    = 8'd33;
        nBus    = 4'd2;
        tick();
        flush   = 1'b0;
        inValid = 1'b0;
        checkOutput("flush_idle_busy", int'(busyOut[0]), 0);
        tick();
        checkOutput("flush_idle_busy2", int'(busyOut[0]), 0);

        // Asynchronous reset in the middle of RUN.
        applyStimulus(8'd0, 4'd5, 1'b0);
        tick();
        checkOutput("pre_reset_busy", int'(busyOut[0]), 1);
        checkOutput("pre_reset_borrow", int'(borrowOut[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkCleared("async_reset");
        for (int i = 0; i < NUM; i++) expQ[i].delete();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        for (int t = 0; t < 80; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int k = 0; k < gap; k++) begin
                outReady = 1'($urandom_range(0, 1));
                tick();
            end
            applyStimulus(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 1'b1);
        end
        drainAll(1'b1);

        for (int i = 0; i < NUM; i++)
            checkOutput($sformatf("u%0d.queue_empty", i), expQ[i].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
